// File: rtl/ahb_arbiter_core_if.sv
// Request/grant bus between AHB masters and the arbiter core.
// The master modport is the requester side; the slave modport is the arbiter side.
interface ahb_arbiter_core_if #(
    parameter int NUM_MASTERS = 4
);
    logic [NUM_MASTERS-1:0] hbusreq;
    logic [NUM_MASTERS-1:0] hlock;
    logic [1:0]             htrans;
    logic [2:0]             hburst;
    logic                   hready;
    logic [NUM_MASTERS-1:0] hgrant;
    logic [3:0]             hmaster;
    logic                   hmastlock;

    modport master (
        output hbusreq, hlock, htrans, hburst, hready,
        input  hgrant, hmaster, hmastlock
    );

    modport slave (
        input  hbusreq, hlock, htrans, hburst, hready,
        output hgrant, hmaster, hmastlock
    );
endinterface

// File: rtl/ahb_arbiter_core.sv
// AHB arbiter: one-hot grant with lock/burst hold and default-master parking.
// Define AHB_ARB_ROUND_ROBIN_EN for round-robin arbitration instead of fixed priority.
module ahb_arbiter_core #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = NUM_MASTERS - 1
) (
    input  logic                hclk,
    input  logic                hreset,
    ahb_arbiter_core_if.slave   bus
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BURST  = 2'd1,
        LOCKED = 2'd2
    } arb_state_e;

    localparam logic [NUM_MASTERS-1:0] DEFAULT_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [3:0]             DEFAULT_IDX   = 4'(DEFAULT_MASTER);

    logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
    logic [3:0]             hmaster_q, hmaster_d;
    logic                   hmastlock_q, hmastlock_d;
    logic [3:0]             beats_left_q, beats_left_d;
    logic [3:0]             grant_idx;
    logic                   owner_lock, owner_req;
    arb_state_e             state_d;
    logic [NUM_MASTERS-1:0] winner;

    function automatic logic [3:0] onehot_to_idx(input logic [NUM_MASTERS-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (oh[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    function automatic logic [3:0] burst_last_beat(input logic [2:0] burst);
        case (burst)
            3'b010, 3'b011: return 4'd3;
            3'b100, 3'b101: return 4'd7;
            3'b110, 3'b111: return 4'd15;
            default:        return 4'd0;
        endcase
    endfunction

`ifdef AHB_ARB_ROUND_ROBIN_EN
    logic [3:0] rr_ptr_q, rr_ptr_d;

    // Winner is the requester closest after the pointer, wrapping around.
    function automatic logic [NUM_MASTERS-1:0] pick(input logic [NUM_MASTERS-1:0] req,
                                                    input logic [3:0]             ptr);
        logic [NUM_MASTERS-1:0] res;
        int best, dist;
        res  = '0;
        best = NUM_MASTERS;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            dist = (i - int'(ptr) - 1 + 2 * NUM_MASTERS) % NUM_MASTERS;
            if (req[i] && dist < best) begin
                best = dist;
                res  = NUM_MASTERS'(1) << i;
            end
        end
        return res;
    endfunction

    assign winner = pick(bus.hbusreq, rr_ptr_q);
`else
    function automatic logic [NUM_MASTERS-1:0] pick(input logic [NUM_MASTERS-1:0] req);
        logic [NUM_MASTERS-1:0] res;
        res = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (req[i]) res = NUM_MASTERS'(1) << i;
        end
        return res;
    endfunction

    assign winner = pick(bus.hbusreq);
`endif

    assign grant_idx  = onehot_to_idx(hgrant_q);
    assign owner_lock = |(bus.hlock & hgrant_q);
    assign owner_req  = |(bus.hbusreq & hgrant_q);

    always_comb begin
        beats_left_d = beats_left_q;
        case (bus.htrans)
            2'b00:   beats_left_d = '0;
            2'b10:   beats_left_d = burst_last_beat(bus.hburst);
            2'b11:   if (beats_left_q != 4'd0) beats_left_d = beats_left_q - 4'd1;
            default: beats_left_d = beats_left_q;
        endcase

        // Decision uses the post-update beat count, so the grant moves on the
        // penultimate beat and the next owner's address phase follows the last.
        if (owner_lock && owner_req)      state_d = LOCKED;
        else if (beats_left_d > 4'd1)     state_d = BURST;
        else                              state_d = FREE;

        hmaster_d   = grant_idx;
        hmastlock_d = owner_lock;
        hgrant_d    = hgrant_q;
        if (state_d == FREE) begin
            hgrant_d = (bus.hbusreq == '0) ? DEFAULT_GRANT : winner;
        end
    end

`ifdef AHB_ARB_ROUND_ROBIN_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_d == FREE && bus.hbusreq != '0) rr_ptr_d = onehot_to_idx(winner);
    end
`endif

    always_ff @(posedge hclk) begin
        if (hreset) begin
            hgrant_q     <= DEFAULT_GRANT;
            hmaster_q    <= DEFAULT_IDX;
            hmastlock_q  <= 1'b0;
            beats_left_q <= '0;
`ifdef AHB_ARB_ROUND_ROBIN_EN
            rr_ptr_q     <= DEFAULT_IDX;
`endif
        end else if (bus.hready) begin
            hgrant_q     <= hgrant_d;
            hmaster_q    <= hmaster_d;
            hmastlock_q  <= hmastlock_d;
            beats_left_q <= beats_left_d;
`ifdef AHB_ARB_ROUND_ROBIN_EN
            rr_ptr_q     <= rr_ptr_d;
`endif
        end
    end

    assign bus.hgrant    = hgrant_q;
    assign bus.hmaster   = hmaster_q;
    assign bus.hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter_core.sv
// Directed plus randomized bench for ahb_arbiter_core with a transaction-level reference model.
module tb_ahb_arbiter_core;
    localparam int NM  = 4;
    localparam int DEF = NM - 1;

    logic hclk = 1'b0;
    logic hreset;
    int   checks   = 0;
    int   failures = 0;

    // Reference model: owner indices and remaining beats as plain integers.
    int m_g, m_mst, m_beats, m_ptr;
    bit m_lock;

    ahb_arbiter_core_if #(.NUM_MASTERS(NM)) bus ();

    ahb_arbiter_core #(.NUM_MASTERS(NM), .DEFAULT_MASTER(DEF)) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus.slave)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int burst_len(input logic [2:0] hb);
        int k;
        k = int'(hb[2:1]);
        return (k == 0) ? 1 : (2 << k);
    endfunction

    task automatic tick();
        int ng, nm, nb, np, c;
        bit nl, own_lock, own_req;
        ng = m_g; nm = m_mst; nl = m_lock; nb = m_beats; np = m_ptr;
        if (hreset) begin
            ng = DEF; nm = DEF; nl = 0; nb = 0; np = DEF;
        end else if (bus.hready) begin
            case (bus.htrans)
                2'b00:   nb = 0;
                2'b01:   nb = m_beats;
                2'b10:   nb = burst_len(bus.hburst) - 1;
                default: nb = (m_beats > 0) ? m_beats - 1 : 0;
            endcase
            own_lock = ((bus.hlock >> m_g) & 4'd1) != 0;
            own_req  = ((bus.hbusreq >> m_g) & 4'd1) != 0;
            nm = m_g;
            nl = own_lock;
            if (!((own_lock && own_req) || nb > 1)) begin
                if (bus.hbusreq == '0) begin
                    ng = DEF;
                end else begin
`ifdef AHB_ARB_ROUND_ROBIN_EN
                    for (int k = 1; k <= NM; k++) begin
                        c = (m_ptr + k) % NM;
                        if (((bus.hbusreq >> c) & 4'd1) != 0) begin
                            ng = c;
                            break;
                        end
                    end
                    np = ng;
`else
                    for (c = NM - 1; c >= 0; c--) begin
                        if (((bus.hbusreq >> c) & 4'd1) != 0) ng = c;
                    end
`endif
                end
            end
        end
        @(posedge hclk);
        #1;
        m_g = ng; m_mst = nm; m_lock = nl; m_beats = nb; m_ptr = np;
        chk("hgrant",    32'(bus.hgrant),    32'(1 << m_g));
        chk("hmaster",   32'(bus.hmaster),   32'(m_mst));
        chk("hmastlock", 32'(bus.hmastlock), 32'(m_lock));
        chk("onehot",    32'($onehot(bus.hgrant)), 32'd1);
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] lck,
                         input logic [1:0] tr, input logic [2:0] hb, input logic rdy);
        bus.hbusreq = req;
        bus.hlock   = lck;
        bus.htrans  = tr;
        bus.hburst  = hb;
        bus.hready  = rdy;
    endtask

    initial begin
        m_g = DEF; m_mst = DEF; m_lock = 0; m_beats = 0; m_ptr = DEF;
        hreset = 1'b1;
        drive(4'b0000, 4'b0000, 2'b00, 3'b000, 1'b1);

        // Reset and idle parking
        tick(); tick();
        chk("rst_hgrant",    32'(bus.hgrant),    32'h8);
        chk("rst_hmaster",   32'(bus.hmaster),   32'd3);
        chk("rst_hmastlock", 32'(bus.hmastlock), 32'd0);
        hreset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("idle_hgrant",  32'(bus.hgrant),  32'h8);
        chk("idle_hmaster", 32'(bus.hmaster), 32'd3);

        // Fixed-priority request, then the same under hready stalls
        drive(4'b0110, 4'b0000, 2'b00, 3'b000, 1'b1);
        tick(); chk("req_hgrant", 32'(bus.hgrant), 32'h2);
        tick(); chk("req_hmaster", 32'(bus.hmaster), 32'd1);
        drive(4'b0000, 4'b0000, 2'b00, 3'b000, 1'b1);
        tick(); tick();
        drive(4'b0110, 4'b0000, 2'b00, 3'b000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hgrant",  32'(bus.hgrant),  32'h8);
            chk("stall_hmaster", 32'(bus.hmaster), 32'd3);
        end
        bus.hready = 1'b1;
        tick(); chk("unstall_hgrant", 32'(bus.hgrant), 32'h2);
        tick(); chk("unstall_hmaster", 32'(bus.hmaster), 32'd1);

        // INCR4 from master 1 with master 0 waiting
        drive(4'b0011, 4'b0000, 2'b10, 3'b011, 1'b1);
        tick(); chk("incr4_nonseq", 32'(bus.hgrant), 32'h2);
        bus.htrans = 2'b11;
        tick(); chk("incr4_seq1", 32'(bus.hgrant), 32'h2);
        tick(); chk("incr4_seq2", 32'(bus.hgrant), 32'h1);
        tick(); chk("incr4_hmaster", 32'(bus.hmaster), 32'd0);

        // Locked sequence on master 2
        drive(4'b0100, 4'b0100, 2'b00, 3'b000, 1'b1);
        tick(); chk("lock_grant", 32'(bus.hgrant), 32'h4);
        tick(); chk("lock_mastlock", 32'(bus.hmastlock), 32'd1);
        bus.hbusreq = 4'b0101;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("lock_hold", 32'(bus.hgrant), 32'h4);
        end
        bus.hlock = 4'b0000;
        tick(); chk("unlock_grant", 32'(bus.hgrant), 32'h1);
        tick(); chk("unlock_mastlock", 32'(bus.hmastlock), 32'd0);

        // Reset in the middle of an INCR8
        drive(4'b0001, 4'b0000, 2'b10, 3'b101, 1'b1);
        tick();
        bus.htrans = 2'b11;
        tick(); tick();
        hreset = 1'b1;
        tick();
        chk("midrst_hgrant",  32'(bus.hgrant),  32'h8);
        chk("midrst_hmaster", 32'(bus.hmaster), 32'd3);
        hreset = 1'b0;
        drive(4'b0010, 4'b0000, 2'b11, 3'b101, 1'b1);
        tick(); chk("midrst_noburst", 32'(bus.hgrant), 32'h2);

        // All masters requesting single transfers
        drive(4'b1111, 4'b0000, 2'b10, 3'b000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
`ifndef AHB_ARB_ROUND_ROBIN_EN
            chk("fixed_prio", 32'(bus.hgrant), 32'h1);
`endif
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            hreset      = ($urandom_range(79) == 0);
            bus.hbusreq = 4'($urandom);
            bus.hlock   = 4'($urandom & $urandom);
            bus.htrans  = 2'($urandom);
            bus.hburst  = 3'($urandom);
            bus.hready  = ($urandom_range(4) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ahb_arbiter_core.md
Name: ahb_arbiter_core

Overview:
- AHB bus arbiter: the responder end of the master request interface.
- Samples hbusreq/hlock from up to 16 masters and drives a one-hot hgrant.
- Tracks the address-phase owner on hmaster/hmastlock.
- Holds the grant through locked sequences and defined-length bursts.
- Parks the bus on the default (lowest-priority) master when nobody requests.

Parameters:
NUM_MASTERS, 4, number of masters (2..16); index 0 has highest priority.
DEFAULT_MASTER, NUM_MASTERS-1, master granted when no request is pending.

Ports:
hclk  input  1  bus clock, all state on rising edge.
hreset  input  1  synchronous, active-high reset.
hbusreq  input  NUM_MASTERS  per-master bus request.
hlock  input  NUM_MASTERS  per-master locked-transfer request.
htrans  input  2  transfer type of current address phase (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
hburst  input  3  burst type of current address phase.
hready  input  1  bus-wide transfer done.
hgrant  output  NUM_MASTERS  one-hot grant, registered.
hmaster  output  4  index of address-phase owner, registered.
hmastlock  output  1  address phase is locked, registered.

Behaviour:
- Reset (hreset=1 at an edge):
  - hgrant = 1<<DEFAULT_MASTER, hmaster = DEFAULT_MASTER, hmastlock = 0.
  - beats_left = 0, state FREE.
  - Reset mid-burst or mid-lock drops all holds immediately.
- hready=0 at an edge: all registers hold their values.
- Edge with hready=1 (owner handover):
  - hmaster <= index of current hgrant.
  - hmastlock <= hlock[that index].
  - Invariant: hgrant&hready at edge E implies hmaster==granted index from E+1.
- Burst counter beats_left, updated only on hready=1 edges:
  - htrans=NONSEQ loads len-1: hburst 010/011 (4-beat) -> 3; 100/101 (8-beat) -> 7; 110/111 (16-beat) -> 15; 000/001 (SINGLE/INCR) -> 0.
  - htrans=SEQ with beats_left>0: decrement.
  - IDLE: clear to 0.
  - BUSY: hold.
  - Counter is 4 bits and never wraps below 0.
- State machine (next state evaluated on hready=1 edges, g = current granted index):
  - LOCKED if hlock[g]=1 and hbusreq[g]=1.
  - else BURST if beats_left' > 1 (beats_left' = post-update value).
  - else FREE.
  - LOCKED has priority over BURST when both apply.
- Grant update at hready=1 edges:
  - Next state LOCKED or BURST: hgrant unchanged.
  - Next state FREE: hgrant <= one-hot of lowest-index asserted hbusreq bit.
  - No request pending: hgrant <= 1<<DEFAULT_MASTER.
  - The current owner dropping hbusreq in FREE loses the grant at that edge.
- hgrant is always exactly one-hot, never zero after reset.
- Latency:
  - Request to grant: 1 hready edge when FREE.
  - Grant to hmaster: 1 further hready edge.

Optional Feature:
- AHB_ARB_ROUND_ROBIN_EN defined:
  - FREE-state arbitration is round-robin.
  - Search starts at (last granted index + 1) mod NUM_MASTERS and takes the first asserted hbusreq.
  - The last-granted pointer updates whenever hgrant changes to a requesting master.
  - The pointer resets to DEFAULT_MASTER.
  - Default-master parking is unchanged.
- Undefined: fixed priority, index 0 highest.

Test Plan:
- Reset with NUM_MASTERS=4 -> hgrant=4'b1000, hmaster=3, hmastlock=0; idle with hbusreq=0 for 10 cycles, hready=1 -> outputs unchanged.
- hbusreq=4'b0110, hready=1 -> next edge hgrant=4'b0010; following edge hmaster=1. Repeat with hready held 0 for 3 cycles -> grant and hmaster frozen until hready=1.
- Master 1 granted and issues NONSEQ hburst=011 (INCR4) then 3 SEQ, hbusreq[0]=1 throughout:
  - grant held at 4'b0010 until the edge where the 2nd SEQ is accepted (beats_left'=1);
  - hgrant=4'b0001 there;
  - hmaster=0 after the next hready edge.
- Master 2 granted with hlock[2]=1, hbusreq=4'b0101 for 6 cycles:
  - hgrant stays 4'b0100; hmastlock=1 from the handover edge;
  - hlock[2] drops -> hgrant=4'b0001 at next hready edge; hmastlock=0 one hready edge later.
- Assert hreset mid-INCR8 (beats_left=5) -> next edge hgrant=4'b1000, hmaster=3, beats_left=0, state FREE.
- With AHB_ARB_ROUND_ROBIN_EN, hbusreq=4'b1111 constantly, single transfers -> grants rotate 0,1,2,3,0 on successive hready edges; without the macro -> grant stays 4'b0001.
